// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the architectural PC, reads one instruction word at a time
// from instruction memory, hands {inst, pc} to decode and waits for commit to supply the next PC.
module ifu_fetch #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,

    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,

    input  logic            rsp_valid,
    input  logic [31:0]     rsp_data,
    input  logic            rsp_err,
    output logic            rsp_ready,

    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    input  logic            inst_ready,

    input  logic            commit_valid,
    input  logic [XLEN-1:0] next_pc,

    output logic            fetch_fault,
    output logic [31:0]     fetch_count
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        HOLD,
        WAIT_COMMIT,
        FAULT
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic            req_valid_q;
    logic            rsp_ready_q;
    logic            inst_valid_q;
    logic            fetch_fault_q;
    logic [31:0]     fetch_count_q;

    logic [31:0]     fetch_count_d;
    logic            next_pc_aligned;

    assign fetch_count_d   = fetch_count_q + 32'd1;
    assign next_pc_aligned = (next_pc[1:0] == 2'b00);

    // Control outputs are registered alongside the state so each one is a pure function of
    // the state register; every transition updates them to match the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inst_q        <= 32'h0;
            req_valid_q   <= 1'b0;
            rsp_ready_q   <= 1'b0;
            inst_valid_q  <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= REQ;
                    req_valid_q <= 1'b1;
                end

                REQ: begin
                    if (req_ready) begin
                        state_q     <= WAIT_RSP;
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                    end
                end

                WAIT_RSP: begin
                    if (rsp_valid) begin
                        rsp_ready_q <= 1'b0;
                        if (rsp_err) begin
                            state_q       <= FAULT;
                            fetch_fault_q <= 1'b1;
                        end else begin
                            state_q      <= HOLD;
                            inst_q       <= rsp_data;
                            inst_valid_q <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (inst_ready) begin
                        state_q       <= WAIT_COMMIT;
                        inst_valid_q  <= 1'b0;
                        fetch_count_q <= fetch_count_d;
                    end
                end

                // A misaligned target is still latched so the faulting PC stays observable.
                WAIT_COMMIT: begin
                    if (commit_valid) begin
                        pc_q <= next_pc;
                        if (next_pc_aligned) begin
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            state_q       <= FAULT;
                            fetch_fault_q <= 1'b1;
                        end
                    end
                end

                FAULT: begin
                    state_q       <= FAULT;
                    req_valid_q   <= 1'b0;
                    rsp_ready_q   <= 1'b0;
                    inst_valid_q  <= 1'b0;
                    fetch_fault_q <= 1'b1;
                end

                default: begin
                    state_q       <= FAULT;
                    req_valid_q   <= 1'b0;
                    rsp_ready_q   <= 1'b0;
                    inst_valid_q  <= 1'b0;
                    fetch_fault_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_valid   = req_valid_q;
    assign req_addr    = pc_q;
    assign rsp_ready   = rsp_ready_q;
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign pc          = pc_q;
    assign fetch_fault = fetch_fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: drives memory, decoder and commit sides; an independent monitor
// checks every request address and delivered instruction against the model's queues.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        rsp_err = 1'b0;
    logic        rsp_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_ready = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] next_pc = 32'h0;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] reqQ[$];
    logic [63:0] instQ[$];
    logic [31:0] modelPc;
    logic [31:0] modelCount;
    logic [63:0] monEntry;

    ifu_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .rsp_ready    (rsp_ready),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .pc           (pc),
        .inst_ready   (inst_ready),
        .commit_valid (commit_valid),
        .next_pc      (next_pc),
        .fetch_fault  (fetch_fault),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) begin
            if (reqQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_request: got addr %h expected no request", req_addr);
            end else begin
                checkOutput("req_addr", req_addr, reqQ.pop_front());
            end
        end
        if (!rst && inst_valid && inst_ready) begin
            if (instQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_inst: got inst %h expected no handoff", inst);
            end else begin
                monEntry = instQ.pop_front();
                checkOutput("inst", inst, monEntry[63:32]);
                checkOutput("pc", pc, monEntry[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_valid"}, {31'h0, req_valid}, 32'h0);
        checkOutput({tag, "_rsp_ready"}, {31'h0, rsp_ready}, 32'h0);
        checkOutput({tag, "_inst_valid"}, {31'h0, inst_valid}, 32'h0);
        checkOutput({tag, "_fetch_fault"}, {31'h0, fetch_fault}, 32'h0);
        checkOutput({tag, "_fetch_count"}, fetch_count, 32'h0);
        checkOutput({tag, "_pc"}, pc, RESET_PC);
        checkOutput({tag, "_req_addr"}, req_addr, RESET_PC);
        checkOutput({tag, "_inst"}, inst, 32'h0);
    endtask

    task automatic doReset();
        rst          = 1'b1;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        rsp_data     = 32'h0;
        inst_ready   = 1'b0;
        commit_valid = 1'b0;
        next_pc      = 32'h0;
        reqQ.delete();
        instQ.delete();
        modelPc      = RESET_PC;
        modelCount   = 32'h0;
        #1;
        checkResetValues("reset");
        tick();
        tick();
        rst = 1'b0;
        reqQ.push_back(RESET_PC);
    endtask

    task automatic checkFaultHeld(input string tag);
        for (int i = 0; i < 3; i++) begin
            req_ready    = 1'b1;
            rsp_valid    = 1'b1;
            inst_ready   = 1'b1;
            commit_valid = 1'b1;
            next_pc      = 32'h8000_0000;
            checkOutput({tag, "_fault"}, {31'h0, fetch_fault}, 32'h1);
            checkOutput({tag, "_req_valid"}, {31'h0, req_valid}, 32'h0);
            checkOutput({tag, "_inst_valid"}, {31'h0, inst_valid}, 32'h0);
            checkOutput({tag, "_rsp_ready"}, {31'h0, rsp_ready}, 32'h0);
            checkOutput({tag, "_pc"}, pc, modelPc);
            tick();
        end
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        inst_ready   = 1'b0;
        commit_valid = 1'b0;
    endtask

    // One complete instruction: request, response, handoff to decode, commit.
    task automatic applyStimulus(input int reqStall, input int rspDelay, input logic [31:0] data,
                                 input bit err, input int instStall, input int commitDelay,
                                 input logic [31:0] nextPc, output bit faulted);
        int n;
        faulted = 1'b0;
        n = 0;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("req_valid_wait", {31'h0, req_valid}, 32'h1);
        for (int i = 0; i < reqStall; i++) begin
            req_ready = 1'b0;
            checkOutput("req_valid_stall", {31'h0, req_valid}, 32'h1);
            checkOutput("req_addr_stall", req_addr, modelPc);
            tick();
        end
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = ~data;
        rsp_err   = 1'b0;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        checkOutput("rsp_ready", {31'h0, rsp_ready}, 32'h1);
        checkOutput("req_valid_after_hs", {31'h0, req_valid}, 32'h0);
        for (int i = 0; i < rspDelay; i++) begin
            checkOutput("inst_valid_wait_rsp", {31'h0, inst_valid}, 32'h0);
            tick();
        end
        rsp_valid = 1'b1;
        rsp_data  = data;
        rsp_err   = err;
        if (!err) instQ.push_back({data, modelPc});
        tick();
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        if (err) begin
            faulted = 1'b1;
            checkFaultHeld("rsp_err");
            return;
        end
        for (int i = 0; i < instStall; i++) begin
            inst_ready   = 1'b0;
            commit_valid = 1'($urandom_range(0, 1));
            next_pc      = 32'hDEAD_BEE2;
            checkOutput("inst_valid_hold", {31'h0, inst_valid}, 32'h1);
            checkOutput("inst_hold", inst, data);
            checkOutput("pc_hold", pc, modelPc);
            checkOutput("count_hold", fetch_count, modelCount);
            tick();
        end
        checkOutput("inst_valid_handoff", {31'h0, inst_valid}, 32'h1);
        inst_ready   = 1'b1;
        commit_valid = 1'b1;
        next_pc      = 32'hDEAD_BEE2;
        tick();
        inst_ready   = 1'b0;
        commit_valid = 1'b0;
        modelCount   = modelCount + 32'd1;
        checkOutput("fetch_count", fetch_count, modelCount);
        checkOutput("inst_valid_after", {31'h0, inst_valid}, 32'h0);
        for (int i = 0; i < commitDelay; i++) begin
            checkOutput("req_valid_wait_commit", {31'h0, req_valid}, 32'h0);
            checkOutput("fault_wait_commit", {31'h0, fetch_fault}, 32'h0);
            tick();
        end
        commit_valid = 1'b1;
        next_pc      = nextPc;
        tick();
        commit_valid = 1'b0;
        modelPc      = nextPc;
        checkOutput("pc_after_commit", pc, modelPc);
        if (nextPc[1:0] != 2'b00) begin
            faulted = 1'b1;
            checkFaultHeld("misaligned");
        end else begin
            reqQ.push_back(nextPc);
            checkOutput("req_valid_after_commit", {31'h0, req_valid}, 32'h1);
            checkOutput("req_addr_after_commit", req_addr, nextPc);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit f;
        int r;
        logic [31:0] np;
        #2;
        doReset();
        tick();
        checkOutput("first_req_valid", {31'h0, req_valid}, 32'h1);
        checkOutput("first_req_addr", req_addr, RESET_PC);

        applyStimulus(4, 0, 32'h0000_0413, 1'b0, 3, 1, 32'h8000_0100, f);
        applyStimulus(0, 2, $urandom(), 1'b0, 0, 0, 32'h8000_0102, f);
        checkOutput("misaligned_faulted", {31'h0, f}, 32'h1);

        doReset();
        applyStimulus(1, 1, $urandom(), 1'b1, 0, 0, 32'h8000_0004, f);
        checkOutput("err_faulted", {31'h0, f}, 32'h1);
        doReset();

        tick();
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        tick();
        release dut.fetch_count_q;
        modelCount = 32'hFFFF_FFFF;
        checkOutput("count_preload", fetch_count, 32'hFFFF_FFFF);
        applyStimulus(0, 0, $urandom(), 1'b0, 0, 0, 32'h8000_0004, f);
        checkOutput("count_wrap", fetch_count, 32'h0);

        doReset();
        tick();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        checkOutput("wait_rsp_rsp_ready", {31'h0, rsp_ready}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("async_reset");
        tick();
        doReset();

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) np = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
            else if (r < 5) np = modelPc + 32'd4;
            else np = $urandom() & 32'hFFFF_FFFC;
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), $urandom(),
                          ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
                          $urandom_range(0, 2), np, f);
            if (f) doReset();
        end

        checkOutput("inst_queue_drained", instQ.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
